bmp_stream_parser: RTL and testbench

- Synthesizable reader for the 24-bpp uncompressed BMP format our bench-side BMP writer produces.
- Consumes a BMP file as a byte stream (file order, little-endian fields) and parses/validates the 54-byte BITMAPFILEHEADER + BITMAPINFOHEADER.
- Skips to bfOffBits, then emits one RGB pixel per accepted triplet with x/y coordinates and frame markers, stripping row padding.
- Sits between a file/DMA byte source and image-processing datapaths.

---
 rtl/bmp_pkg.sv | 46 ++++
 rtl/bmp_stream_parser_if.sv | 27 ++
 rtl/bmp_pix_assembler.sv | 79 +++++++
 rtl/bmp_stream_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_bmp_stream_parser.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmp_pkg.sv
// Shared constants, header field offsets, error codes and parser states for
// the 24-bpp BMP stream parser.
package bmp_pkg;

  localparam int unsigned BMP_HDR_BYTES   = 54;
  localparam logic [15:0] BMP_MAGIC       = 16'h424D;

  localparam int unsigned OFS_OFF_BITS    = 10;
  localparam int unsigned OFS_WIDTH       = 18;
  localparam int unsigned OFS_HEIGHT      = 22;
  localparam int unsigned OFS_BIT_COUNT   = 28;
  localparam int unsigned OFS_COMPRESSION = 30;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_MAGIC       = 3'd1,
    ERR_BPP         = 3'd2,
    ERR_COMPRESSION = 3'd3,
    ERR_DIMENSIONS  = 3'd4,
    ERR_OFFSET      = 3'd5
  } bmp_err_e;

  typedef enum logic [2:0] {
    HDR,
    SKIP,
    PIXEL,
    PAD,
    DONE,
    ERROR
  } parser_state_e;

  // Priority encoder: the lowest-numbered failing check is reported.
  function automatic bmp_err_e selectError(input logic magicBad,
                                           input logic bppBad,
                                           input logic compBad,
                                           input logic dimBad,
                                           input logic offBad);
    if (magicBad)     return ERR_MAGIC;
    else if (bppBad)  return ERR_BPP;
    else if (compBad) return ERR_COMPRESSION;
    else if (dimBad)  return ERR_DIMENSIONS;
    else if (offBad)  return ERR_OFFSET;
    else              return ERR_NONE;
  endfunction

endpackage

// File: rtl/bmp_stream_parser_if.sv
// Byte-in / pixel-out handshake bundle of the BMP parser.
// master = parser side, slave = byte source / pixel sink side.
interface bmp_stream_parser_if #(parameter int DIM_W = 13);

  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [23:0]      m_pixel;
  logic [DIM_W-1:0] m_x;
  logic [DIM_W-1:0] m_y;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  s_data, s_valid, m_ready,
    output s_ready, m_pixel, m_x, m_y, m_sof, m_eol, m_eof, m_valid
  );

  modport slave (
    output s_data, s_valid, m_ready,
    input  s_ready, m_pixel, m_x, m_y, m_sof, m_eol, m_eof, m_valid
  );

endinterface

// File: rtl/bmp_pix_assembler.sv
// Collects B,G,R file bytes into one {R,G,B} pixel and holds it in a
// single-entry output register with its coordinates and frame markers.
module bmp_pix_assembler
  import bmp_pkg::*;
#(
  parameter int DIM_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byteData,
  input  logic             byteValid,
  output logic             byteReady,
  output logic             pixelTake,
  input  logic [DIM_W-1:0] pixX,
  input  logic [DIM_W-1:0] pixY,
  input  logic             pixSof,
  input  logic             pixEol,
  input  logic             pixEof,
  output logic [23:0]      outPixel,
  output logic [DIM_W-1:0] outX,
  output logic [DIM_W-1:0] outY,
  output logic             outSof,
  output logic             outEol,
  output logic             outEof,
  output logic             outValid,
  input  logic             outReady
);

  logic [1:0] phase;
  logic [7:0] blue;
  logic [7:0] green;

  // Only the R byte needs a free slot; it may land while the old pixel leaves.
  always_comb begin
    byteReady = !((phase == 2'd2) && outValid && !outReady);
    pixelTake = byteValid && byteReady && (phase == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= 2'd0;
      blue     <= 8'd0;
      green    <= 8'd0;
      outPixel <= 24'd0;
      outX     <= '0;
      outY     <= '0;
      outSof   <= 1'b0;
      outEol   <= 1'b0;
      outEof   <= 1'b0;
      outValid <= 1'b0;
    end else begin
      if (byteValid && byteReady) begin
        case (phase)
          2'd0: begin
            blue  <= byteData;
            phase <= 2'd1;
          end
          2'd1: begin
            green <= byteData;
            phase <= 2'd2;
          end
          default: phase <= 2'd0;
        endcase
      end
      if (pixelTake) begin
        outPixel <= {byteData, green, blue};
        outX     <= pixX;
        outY     <= pixY;
        outSof   <= pixSof;
        outEol   <= pixEol;
        outEof   <= pixEof;
        outValid <= 1'b1;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bmp_stream_parser.sv
// 24-bpp uncompressed BMP byte-stream parser: header check, offset skip,
// pixel extraction with row-padding removal. Optional macro BMP_TOPDOWN_EN
// accepts negative biHeight (top-down row order).
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int MAX_HRES = 4096,
  parameter int MAX_VRES = 4096,
  parameter int DIM_W    = 13
) (
  input  logic             clk,
  input  logic             rst,
  bmp_stream_parser_if.master bus,
  output logic             hdr_valid,
  output logic [DIM_W-1:0] img_width,
  output logic [DIM_W-1:0] img_height,
  output logic             hdr_error,
  output logic [2:0]       err_code
);

`ifdef BMP_TOPDOWN_EN
  localparam bit TOPDOWN_OK = 1'b1;
`else
  localparam bit TOPDOWN_OK = 1'b0;
`endif

  parser_state_e    state;
  logic [31:0]      byteCnt;
  logic [15:0]      magic;
  logic [31:0]      offBits;
  logic [31:0]      hdrWidth;
  logic [31:0]      hdrHeight;
  logic [15:0]      bitCount;
  logic [31:0]      compression;
  logic [DIM_W-1:0] curX;
  logic [DIM_W-1:0] curY;
  logic             topDown;
  logic             firstPix;
  logic [1:0]       padLeft;

  logic             fire;
  logic             asmValid;
  logic             asmReady;
  logic             pixelTake;
  logic             heightNeg;
  logic [31:0]      absHeight;
  logic             dimBad;
  bmp_err_e         errSel;
  logic             lastX;
  logic             lastRow;
  logic [DIM_W-1:0] nextY;

  // Header validation is evaluated continuously; it is only acted on at byte 53.
  always_comb begin
    heightNeg = hdrHeight[31];
    absHeight = heightNeg ? (~hdrHeight + 32'd1) : hdrHeight;
    dimBad    = (hdrWidth == 32'd0) || (hdrWidth > 32'(MAX_HRES)) ||
                (hdrHeight == 32'd0) || (absHeight > 32'(MAX_VRES)) ||
                (heightNeg && !TOPDOWN_OK);
    errSel    = selectError(magic != BMP_MAGIC,
                            bitCount != 16'd24,
                            compression != 32'd0,
                            dimBad,
                            offBits < 32'(BMP_HDR_BYTES));
  end

  always_comb begin
    lastX   = (curX == img_width - DIM_W'(1));
    lastRow = topDown ? (curY == img_height - DIM_W'(1)) : (curY == '0);
    nextY   = topDown ? (curY + DIM_W'(1)) : (curY - DIM_W'(1));
  end

  always_comb begin
    bus.s_ready = 1'b0;
    case (state)
      HDR, SKIP, PAD, ERROR: bus.s_ready = 1'b1;
      PIXEL:                 bus.s_ready = asmReady;
      default:               bus.s_ready = 1'b0;
    endcase
    fire     = bus.s_valid && bus.s_ready;
    asmValid = bus.s_valid && (state == PIXEL);
  end

  bmp_pix_assembler #(.DIM_W(DIM_W)) u_assembler (
    .clk      (clk),
    .rst      (rst),
    .byteData (bus.s_data),
    .byteValid(asmValid),
    .byteReady(asmReady),
    .pixelTake(pixelTake),
    .pixX     (curX),
    .pixY     (curY),
    .pixSof   (firstPix),
    .pixEol   (lastX),
    .pixEof   (lastX && lastRow),
    .outPixel (bus.m_pixel),
    .outX     (bus.m_x),
    .outY     (bus.m_y),
    .outSof   (bus.m_sof),
    .outEol   (bus.m_eol),
    .outEof   (bus.m_eof),
    .outValid (bus.m_valid),
    .outReady (bus.m_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR;
      byteCnt     <= 32'd0;
      magic       <= 16'd0;
      offBits     <= 32'd0;
      hdrWidth    <= 32'd0;
      hdrHeight   <= 32'd0;
      bitCount    <= 16'd0;
      compression <= 32'd0;
      curX        <= '0;
      curY        <= '0;
      topDown     <= 1'b0;
      firstPix    <= 1'b0;
      padLeft     <= 2'd0;
      hdr_valid   <= 1'b0;
      img_width   <= '0;
      img_height  <= '0;
      hdr_error   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      case (state)
        HDR: begin
          if (fire) begin
            byteCnt <= byteCnt + 32'd1;
            case (byteCnt)
              32'd0:               magic[15:8]        <= bus.s_data;
              32'd1:               magic[7:0]         <= bus.s_data;
              OFS_OFF_BITS:        offBits[7:0]       <= bus.s_data;
              OFS_OFF_BITS + 1:    offBits[15:8]      <= bus.s_data;
              OFS_OFF_BITS + 2:    offBits[23:16]     <= bus.s_data;
              OFS_OFF_BITS + 3:    offBits[31:24]     <= bus.s_data;
              OFS_WIDTH:           hdrWidth[7:0]      <= bus.s_data;
              OFS_WIDTH + 1:       hdrWidth[15:8]     <= bus.s_data;
              OFS_WIDTH + 2:       hdrWidth[23:16]    <= bus.s_data;
              OFS_WIDTH + 3:       hdrWidth[31:24]    <= bus.s_data;
              OFS_HEIGHT:          hdrHeight[7:0]     <= bus.s_data;
              OFS_HEIGHT + 1:      hdrHeight[15:8]    <= bus.s_data;
              OFS_HEIGHT + 2:      hdrHeight[23:16]   <= bus.s_data;
              OFS_HEIGHT + 3:      hdrHeight[31:24]   <= bus.s_data;
              OFS_BIT_COUNT:       bitCount[7:0]      <= bus.s_data;
              OFS_BIT_COUNT + 1:   bitCount[15:8]     <= bus.s_data;
              OFS_COMPRESSION:     compression[7:0]   <= bus.s_data;
              OFS_COMPRESSION + 1: compression[15:8]  <= bus.s_data;
              OFS_COMPRESSION + 2: compression[23:16] <= bus.s_data;
              OFS_COMPRESSION + 3: compression[31:24] <= bus.s_data;
              default: ;
            endcase
            if (byteCnt == 32'(BMP_HDR_BYTES - 1)) begin
              if (errSel != ERR_NONE) begin
                state     <= ERROR;
                hdr_error <= 1'b1;
                err_code  <= errSel;
              end else begin
                hdr_valid  <= 1'b1;
                img_width  <= hdrWidth[DIM_W-1:0];
                img_height <= absHeight[DIM_W-1:0];
                topDown    <= heightNeg;
                curX       <= '0;
                curY       <= heightNeg ? '0 : (absHeight[DIM_W-1:0] - DIM_W'(1));
                firstPix   <= 1'b1;
                state      <= (offBits > 32'(BMP_HDR_BYTES)) ? SKIP : PIXEL;
              end
            end
          end
        end

        SKIP: begin
          if (fire) begin
            byteCnt <= byteCnt + 32'd1;
            if (byteCnt + 32'd1 == offBits) state <= PIXEL;
          end
        end

        // Row advance is deferred past the pad bytes so lastRow stays valid in PAD.
        PIXEL: begin
          if (pixelTake) begin
            firstPix <= 1'b0;
            if (lastX) begin
              curX <= '0;
              if (img_width[1:0] != 2'd0) begin
                padLeft <= img_width[1:0];
                state   <= PAD;
              end else if (lastRow) begin
                state <= DONE;
              end else begin
                curY <= nextY;
              end
            end else begin
              curX <= curX + DIM_W'(1);
            end
          end
        end

        PAD: begin
          if (fire) begin
            padLeft <= padLeft - 2'd1;
            if (padLeft == 2'd1) begin
              if (lastRow) begin
                state <= DONE;
              end else begin
                curY  <= nextY;
                state <= PIXEL;
              end
            end
          end
        end

        // Wait for the end-of-frame pixel to leave, then expect the next file.
        DONE: begin
          if (!bus.m_valid || bus.m_ready) begin
            hdr_valid <= 1'b0;
            byteCnt   <= 32'd0;
            state     <= HDR;
          end
        end

        ERROR: ;

        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed self-checking bench for bmp_stream_parser: header parse, padding,
// offset skip, backpressure, error codes, mid-frame reset, top-down option.
module tb_bmp_stream_parser;

  localparam int DIM_W = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             hdr_valid;
  logic [DIM_W-1:0] img_width;
  logic [DIM_W-1:0] img_height;
  logic             hdr_error;
  logic [2:0]       err_code;

  always #5 clk = ~clk;

  bmp_stream_parser_if #(.DIM_W(DIM_W)) bus ();

  bmp_stream_parser #(.MAX_HRES(4096), .MAX_VRES(4096), .DIM_W(DIM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .hdr_valid (hdr_valid),
    .img_width (img_width),
    .img_height(img_height),
    .hdr_error (hdr_error),
    .err_code  (err_code)
  );

  int          checks = 0;
  int          errors = 0;
  int          stallCnt = 0;
  int          readyBad = 0;
  int          stableBad = 0;
  int          timeouts = 0;
  bit          stallMode = 1'b0;
  logic [7:0]  fileQ[$];
  logic [52:0] capQ[$];
  int          curW = 1;
  int          curOff = 54;

  typedef struct {
    logic [7:0] magic0;
    int         w;
    int         h;
    int         off;
    int         bpp;
    int         comp;
    logic [2:0] code;
  } errCase_t;

  // Sink ready: always 1, or a coin flip per cycle in stall mode.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.m_ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Capture accepted pixels and watch output stability while stalled.
  logic [52:0] held;
  bit          holdPending = 1'b0;
  always @(negedge clk) begin
    logic [52:0] cur;
    #4;
    cur = {bus.m_pixel, bus.m_x, bus.m_y, bus.m_sof, bus.m_eol, bus.m_eof};
    if (rst) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending && (!bus.m_valid || cur !== held)) stableBad++;
      holdPending = bus.m_valid && !bus.m_ready;
      held = cur;
      if (bus.m_valid && bus.m_ready) capQ.push_back(cur);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one byte from a negedge and returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] b, input bit firstOfFile, input bit isR);
    int n = 0;
    bit acc;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    do begin
      #4;
      acc = bus.s_ready;
      if (!acc) stallCnt++;
      if (!acc && !firstOfFile && !(isR && bus.m_valid && !bus.m_ready)) readyBad++;
      @(negedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) timeouts++;
  endtask

  task automatic put32(input int ofs, input logic [31:0] v);
    for (int j = 0; j < 4; j++) fileQ[ofs + j] = v[8*j +: 8];
  endtask

  task automatic buildFile(input logic [7:0] magic0, input int w, input int h,
                           input int off, input int bpp, input int comp, input bit withPixels);
    int rows = (h < 0) ? -h : h;
    int stride = ((3 * w + 3) / 4) * 4;
    fileQ.delete();
    for (int i = 0; i < 54; i++) fileQ.push_back(8'h00);
    fileQ[0] = magic0;
    fileQ[1] = 8'h4D;
    put32(10, 32'(off));
    put32(14, 32'd40);
    put32(18, 32'(w));
    put32(22, 32'(h));
    fileQ[26] = 8'h01;
    fileQ[28] = 8'(bpp);
    fileQ[29] = 8'(bpp >> 8);
    put32(30, 32'(comp));
    for (int i = 54; i < off; i++) fileQ.push_back(8'hAA);
    if (withPixels) begin
      for (int k = 0; k < rows * stride; k++)
        fileQ.push_back(((k % stride) < 3 * w) ? 8'(k) : 8'hEE);
    end
    curW = w;
    curOff = off;
  endtask

  function automatic bit isRByte(input int i);
    int stride = ((3 * curW + 3) / 4) * 4;
    int q;
    if (i < curOff || stride == 0) return 1'b0;
    q = (i - curOff) % stride;
    return (q < 3 * curW) && ((q % 3) == 2);
  endfunction

  task automatic sendRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(fileQ[i], i == 0, isRByte(i));
    bus.s_valid = 1'b0;
  endtask

  task automatic waitPixels(input int n, input int budget);
    int t = 0;
    while (capQ.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Expected stream: pixel-array byte k carries k mod 256, pads carry 0xEE.
  task automatic checkFrame(input string tag, input int w, input int h, input bit topDown, input int nRows);
    int stride = ((3 * w + 3) / 4) * 4;
    for (int r = 0; r < nRows; r++) begin
      for (int c = 0; c < w; c++) begin
        int k = r * w + c;
        int base = r * stride + 3 * c;
        logic [52:0] exp;
        logic [52:0] obs;
        exp = {8'(base + 2), 8'(base + 1), 8'(base), DIM_W'(c),
               DIM_W'(topDown ? r : h - 1 - r), k == 0, c == w - 1,
               (r == h - 1) && (c == w - 1)};
        obs = (k < capQ.size()) ? capQ[k] : '0;
        checkOutput($sformatf("%s px%0d", tag, k), 64'(obs), 64'(exp));
      end
    end
  endtask

  errCase_t errCases[7];

  initial begin
    errCases[0] = '{8'h41, 2, 2, 54, 24, 0, 3'd1};
    errCases[1] = '{8'h42, 2, 2, 54, 32, 0, 3'd2};
    errCases[2] = '{8'h42, 2, 2, 54, 24, 1, 3'd3};
    errCases[3] = '{8'h42, 0, 2, 54, 24, 0, 3'd4};
    errCases[4] = '{8'h42, 2, 2, 40, 24, 0, 3'd5};
    errCases[5] = '{8'h42, 2, 2, 54, 32, 1, 3'd2};
    errCases[6] = '{8'h42, 4097, 1, 54, 24, 0, 3'd4};

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    resetDut();

    $display("[TB] reset state");
    checkOutput("reset m_valid", bus.m_valid, 1'b0);
    checkOutput("reset hdr_valid", hdr_valid, 1'b0);
    checkOutput("reset hdr_error", hdr_error, 1'b0);
    checkOutput("reset err_code", err_code, 3'd0);
    checkOutput("reset img_width", img_width, '0);
    checkOutput("reset s_ready", bus.s_ready, 1'b1);

    $display("[TB] 512x512 header, first row, then reset mid-array");
    buildFile(8'h42, 512, 512, 54, 24, 0, 1'b0);
    for (int k = 0; k < 1540; k++) fileQ.push_back(8'(k));
    stallCnt = 0;
    capQ.delete();
    sendRange(0, 52);
    checkOutput("hdr_valid before byte 53", hdr_valid, 1'b0);
    sendRange(53, 53);
    checkOutput("hdr_valid after byte 53", hdr_valid, 1'b1);
    checkOutput("512 img_width", img_width, 13'd512);
    checkOutput("512 img_height", img_height, 13'd512);
    sendRange(54, 54 + 1535);
    waitPixels(512, 20);
    checkOutput("512 row pixel count", capQ.size(), 512);
    checkFrame("512row", 512, 512, 1'b0, 1);
    checkOutput("512 s_ready stalls", stallCnt, 0);
    sendRange(54 + 1536, 54 + 1539);
    resetDut();
    checkOutput("midreset m_valid", bus.m_valid, 1'b0);
    checkOutput("midreset hdr_valid", hdr_valid, 1'b0);
    checkOutput("midreset img_width", img_width, '0);

    $display("[TB] fresh 2x2 file after reset");
    capQ.delete();
    buildFile(8'h42, 2, 2, 54, 24, 0, 1'b1);
    sendRange(0, fileQ.size() - 1);
    waitPixels(4, 20);
    repeat (3) @(negedge clk);
    checkOutput("2x2 pixel count", capQ.size(), 4);
    checkFrame("2x2", 2, 2, 1'b0, 2);
    checkOutput("2x2 hdr_valid dropped", hdr_valid, 1'b0);

    $display("[TB] 3x2 file with padding");
    capQ.delete();
    buildFile(8'h42, 3, 2, 54, 24, 0, 1'b1);
    sendRange(0, fileQ.size() - 1);
    waitPixels(6, 20);
    repeat (3) @(negedge clk);
    checkOutput("3x2 pixel count", capQ.size(), 6);
    checkFrame("3x2", 3, 2, 1'b0, 2);

    $display("[TB] bfOffBits 0x46 gap skip");
    capQ.delete();
    buildFile(8'h42, 4, 1, 70, 24, 0, 1'b1);
    sendRange(0, fileQ.size() - 1);
    waitPixels(4, 20);
    repeat (3) @(negedge clk);
    checkOutput("gap pixel count", capQ.size(), 4);
    checkFrame("gap", 4, 1, 1'b0, 1);

    $display("[TB] 4x4 with random m_ready");
    capQ.delete();
    readyBad = 0;
    stableBad = 0;
    stallMode = 1'b1;
    buildFile(8'h42, 4, 4, 54, 24, 0, 1'b1);
    sendRange(0, fileQ.size() - 1);
    waitPixels(16, 200);
    stallMode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stall pixel count", capQ.size(), 16);
    checkFrame("stall", 4, 4, 1'b0, 4);
    checkOutput("stall s_ready rule", readyBad, 0);
    checkOutput("stall output stability", stableBad, 0);

    $display("[TB] width 4096 boundary accepted");
    resetDut();
    buildFile(8'h42, 4096, 1, 54, 24, 0, 1'b0);
    sendRange(0, 53);
    checkOutput("w4096 hdr_valid", hdr_valid, 1'b1);
    checkOutput("w4096 img_width", img_width, 13'd4096);
    checkOutput("w4096 hdr_error", hdr_error, 1'b0);

    $display("[TB] header error cases");
    for (int e = 0; e < 7; e++) begin
      resetDut();
      capQ.delete();
      buildFile(errCases[e].magic0, errCases[e].w, errCases[e].h, errCases[e].off,
                errCases[e].bpp, errCases[e].comp, 1'b0);
      sendRange(0, 53);
      for (int d = 0; d < 8; d++) applyStimulus(8'h55, 1'b0, 1'b0);
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput($sformatf("err%0d err_code", e), err_code, errCases[e].code);
      checkOutput($sformatf("err%0d hdr_error", e), hdr_error, 1'b1);
      checkOutput($sformatf("err%0d hdr_valid", e), hdr_valid, 1'b0);
      checkOutput($sformatf("err%0d no pixels", e), capQ.size(), 0);
      checkOutput($sformatf("err%0d s_ready", e), bus.s_ready, 1'b1);
    end

    $display("[TB] clean file after error and reset");
    resetDut();
    checkOutput("post-error err_code cleared", err_code, 3'd0);
    capQ.delete();
    buildFile(8'h42, 2, 2, 54, 24, 0, 1'b1);
    sendRange(0, fileQ.size() - 1);
    waitPixels(4, 20);
    repeat (3) @(negedge clk);
    checkOutput("recover pixel count", capQ.size(), 4);
    checkFrame("recover", 2, 2, 1'b0, 2);

    $display("[TB] negative biHeight");
    resetDut();
    capQ.delete();
    buildFile(8'h42, 2, -2, 54, 24, 0, 1'b1);
    sendRange(0, 53);
`ifdef BMP_TOPDOWN_EN
    checkOutput("topdown hdr_valid", hdr_valid, 1'b1);
    checkOutput("topdown img_height", img_height, 13'd2);
    sendRange(54, fileQ.size() - 1);
    waitPixels(4, 20);
    repeat (3) @(negedge clk);
    checkOutput("topdown pixel count", capQ.size(), 4);
    checkFrame("topdown", 2, 2, 1'b1, 2);
`else
    repeat (2) @(negedge clk);
    checkOutput("negheight err_code", err_code, 3'd4);
    checkOutput("negheight hdr_error", hdr_error, 1'b1);
`endif

    checkOutput("byte accept timeouts", timeouts, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
